// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, fault causes
// and the sequential fetch stride.
package fetch_unit_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } fetch_state_t;

  typedef enum logic {
    FAULT_BUS_ERR    = 1'b0,
    FAULT_MISALIGNED = 1'b1
  } fetch_fault_cause_t;

  localparam logic [31:0] FETCH_STRIDE = 32'd4;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time, holds the
// returned word for downstream and handles execute-stage redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  input  logic        imem_resp_err_i,
  output logic [31:0] ir_o,
  output logic [31:0] pc_o,
  output logic        ir_valid_o,
  input  logic        ir_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        fault_o,
  output logic        fault_cause_o
);

  fetch_state_t       state_q, state_d;
  fetch_fault_cause_t cause_q, cause_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic [31:0]        ir_q, ir_d;
  logic [31:0]        ir_pc_q, ir_pc_d;
  logic               ir_valid_q, ir_valid_d;
  logic               fault_q, fault_d;
  logic               kill_q, kill_d;
  logic [31:0]        pc_next;

  assign pc_next = pc_q + FETCH_STRIDE;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      cause_q    <= FAULT_BUS_ERR;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      ir_q       <= 32'h0;
      ir_pc_q    <= RESET_PC;
      ir_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      fault_q    <= fault_d;
      kill_q     <= kill_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    fault_d    = fault_q;
    kill_d     = kill_q;

    unique case (state_q)
      IDLE: begin
        req_addr_d = pc_q;
        state_d    = REQ;
      end
      REQ: begin
        if (imem_req_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (imem_resp_valid_i) begin
          if (kill_q) begin
            kill_d     = 1'b0;
            req_addr_d = pc_q;
            state_d    = REQ;
          end else if (imem_resp_err_i) begin
            fault_d = 1'b1;
            cause_d = FAULT_BUS_ERR;
            state_d = FAULT;
          end else begin
            ir_d       = imem_resp_data_i;
            ir_pc_d    = req_addr_q;
            ir_valid_d = 1'b1;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (ir_ready_i) begin
          ir_valid_d = 1'b0;
          pc_d       = pc_next;
          req_addr_d = pc_next;
          state_d    = REQ;
        end
      end
      FAULT: begin
        if (kill_q && imem_resp_valid_i) kill_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything above; an accepted request is never abandoned,
    // its response is marked for dropping instead.
    if (redirect_i && state_q != IDLE) begin
      ir_d       = ir_q;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = 1'b0;
      if (is_misaligned(redirect_pc_i)) begin
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        fault_d    = 1'b1;
        cause_d    = FAULT_MISALIGNED;
        state_d    = FAULT;
        unique case (state_q)
          REQ:     kill_d = imem_req_ready_i;
          WAIT:    kill_d = !imem_resp_valid_i;
          FAULT:   kill_d = kill_q && !imem_resp_valid_i;
          default: kill_d = 1'b0;
        endcase
      end else begin
        pc_d    = redirect_pc_i;
        fault_d = 1'b0;
        cause_d = cause_q;
        unique case (state_q)
          REQ: begin
            req_addr_d = req_addr_q;
            kill_d     = 1'b1;
            state_d    = imem_req_ready_i ? WAIT : REQ;
          end
          WAIT: begin
            if (imem_resp_valid_i) begin
              kill_d     = 1'b0;
              req_addr_d = redirect_pc_i;
              state_d    = REQ;
            end else begin
              kill_d  = 1'b1;
              state_d = WAIT;
            end
          end
          FAULT: begin
            req_addr_d = redirect_pc_i;
            if (kill_q && !imem_resp_valid_i) begin
              state_d = WAIT;
            end else begin
              kill_d  = 1'b0;
              state_d = REQ;
            end
          end
          default: begin
            req_addr_d = redirect_pc_i;
            kill_d     = 1'b0;
            state_d    = REQ;
          end
        endcase
      end
    end
  end

  assign imem_req_valid_o = (state_q == REQ);
  assign imem_req_addr_o  = req_addr_q;
  assign ir_o             = ir_q;
  assign pc_o             = ir_pc_q;
  assign ir_valid_o       = ir_valid_q;
  assign fault_o          = fault_q;
  assign fault_cause_o    = cause_q;

endmodule
